data_mem_arbiter: RTL

- Shares the single-port data memory between two requesters: the CPU load/store port (port C) and a DMA/debug port (port D).
- Each requester issues one word access at a time. The arbiter picks a winner round-robin, drives the memory's write-enable, address and write-data inputs from registered values, and captures read data.
- Reports completion with a one-cycle done pulse per transaction.
- Sits between the multi-cycle CPU datapath and the data memory; the memory's combinational read port feeds back into this block.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 29 ++
 rtl/data_mem_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the CPU data-memory path.
//   arb_state_t : arbiter FSM states (IDLE -> ACCESS -> DONE -> IDLE)
//   arb_port_t  : requester identity, PORT_C (CPU) or PORT_D (DMA/debug)
//   DMEM_DEPTH  : number of words in the data memory
//   DMEM_ADR_W  : word-address width needed to index DMEM_DEPTH words
// ---------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

  typedef enum logic {
    PORT_C,
    PORT_D
  } arb_port_t;

  localparam int DMEM_DEPTH = 512;
  localparam int DMEM_ADR_W = $clog2(DMEM_DEPTH);

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin pick, purely combinational.
// Ports:
//   req_i   [1:0] request vector, bit 0 = port C, bit 1 = port D
//   last_i        port that won the most recent transaction
//   grant_o       chosen port; only meaningful while req_i != 0
// ---------------------------------------------------------------------------
module rr_arb2
  import cpu_pkg::*;
(
  input  logic [1:0] req_i,
  input  arb_port_t  last_i,
  output arb_port_t  grant_o
);

  // A lone requester always wins. Under contention the port that did not
  // win last time goes next, so two busy ports strictly alternate.
  always_comb begin
    grant_o = PORT_C;
    case (req_i)
      2'b01:   grant_o = PORT_C;
      2'b10:   grant_o = PORT_D;
      2'b11:   grant_o = (last_i == PORT_C) ? PORT_D : PORT_C;
      default: grant_o = PORT_C;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Shares the single-port data memory between the CPU load/store port (C)
// and a DMA/debug port (D). Each transaction takes exactly three cycles:
// IDLE (grant and latch) -> ACCESS (memory driven) -> DONE (done pulse).
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   c_req/c_we/c_adr/c_wd port C request, write flag, word address, data
//   c_done/c_rd/c_err     port C completion pulse, read data, range error
//   d_*                   same set for port D
//   mem_we/mem_adr/mem_wd memory write enable, word address, write data
//   mem_rd                memory combinational read data
//   busy                  high while a transaction is in ACCESS or DONE
// ---------------------------------------------------------------------------
module data_mem_arbiter
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = DMEM_DEPTH,
  parameter int ADR_W = DMEM_ADR_W
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             c_req,
  input  logic             c_we,
  input  logic [WIDTH-1:0] c_adr,
  input  logic [WIDTH-1:0] c_wd,
  output logic             c_done,
  output logic [WIDTH-1:0] c_rd,
  output logic             c_err,

  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_adr,
  input  logic [WIDTH-1:0] d_wd,
  output logic             d_done,
  output logic [WIDTH-1:0] d_rd,
  output logic             d_err,

  output logic             mem_we,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd,

  output logic             busy
);

  localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

  arb_state_t       state_q,   state_d;
  arb_port_t        rrLast_q,  rrLast_d;
  arb_port_t        owner_q,   owner_d;
  logic             we_q,      we_d;
  logic [ADR_W-1:0] adr_q,     adr_d;
  logic [WIDTH-1:0] wd_q,      wd_d;
  logic             inRange_q, inRange_d;
  logic [WIDTH-1:0] rdata_q,   rdata_d;
  logic             err_q,     err_d;

  arb_port_t        grant;
  logic             selWe;
  logic [WIDTH-1:0] selAdr;
  logic [WIDTH-1:0] selWd;

  rr_arb2 u_rr_arb2 (
    .req_i   ({d_req, c_req}),
    .last_i  (rrLast_q),
    .grant_o (grant)
  );

  // Request fields of whichever port the round-robin pick favours; these
  // are only sampled on the grant edge out of IDLE.
  assign selWe  = (grant == PORT_D) ? d_we  : c_we;
  assign selAdr = (grant == PORT_D) ? d_adr : c_adr;
  assign selWd  = (grant == PORT_D) ? d_wd  : c_wd;

  // State and latched transaction registers. rrLast resets to D so that
  // port C wins the first contention after reset. Memory contents are
  // outside this block and are not affected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rrLast_q  <= PORT_D;
      owner_q   <= PORT_C;
      we_q      <= 1'b0;
      adr_q     <= '0;
      wd_q      <= '0;
      inRange_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rrLast_q  <= rrLast_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      wd_q      <= wd_d;
      inRange_q <= inRange_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic. The range check uses the full requester address, but
  // only the low ADR_W bits are kept; an out-of-range access never writes
  // and always returns zero with err set.
  always_comb begin
    state_d   = state_q;
    rrLast_d  = rrLast_q;
    owner_d   = owner_q;
    we_d      = we_q;
    adr_d     = adr_q;
    wd_d      = wd_q;
    inRange_d = inRange_q;
    rdata_d   = rdata_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (c_req || d_req) begin
          owner_d   = grant;
          we_d      = selWe;
          adr_d     = selAdr[ADR_W-1:0];
          wd_d      = selWd;
          inRange_d = (selAdr < DEPTH_W);
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        // The memory's combinational read port is sampled on the same edge
        // that commits a write, so reads and writes both finish here.
        rdata_d = (inRange_q && !we_q) ? mem_rd : '0;
        err_d   = !inRange_q;
        state_d = DONE;
      end
      DONE: begin
        rrLast_d = owner_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode directly from the state register, so an asynchronous
  // reset drops mem_we and any done pulse immediately. Only the owning
  // port sees done/rd/err; everything else stays zero.
  always_comb begin
    mem_we  = 1'b0;
    mem_adr = '0;
    mem_wd  = '0;
    c_done  = 1'b0;
    c_rd    = '0;
    c_err   = 1'b0;
    d_done  = 1'b0;
    d_rd    = '0;
    d_err   = 1'b0;
    busy    = 1'b0;

    case (state_q)
      ACCESS: begin
        busy    = 1'b1;
        mem_we  = we_q && inRange_q;
        mem_adr = {{(WIDTH-ADR_W){1'b0}}, adr_q};
        mem_wd  = wd_q;
      end
      DONE: begin
        busy = 1'b1;
        if (owner_q == PORT_C) begin
          c_done = 1'b1;
          c_rd   = rdata_q;
          c_err  = err_q;
        end else begin
          d_done = 1'b1;
          d_rd   = rdata_q;
          d_err  = err_q;
        end
      end
      default: begin
      end
    endcase
  end

endmodule
